// File: rtl/control_pkg.sv
// ----------------------------------------------------------------------------
// control_pkg
// Shared definitions for the multicycle MIPS control path:
//   - MIPS opcode constants (IR[31:26])
//   - main FSM state encoding
//   - 3-bit ula_operation codes (also consumed by the ALU control decoder)
//   - ula_src_b / pc_source mux select constants
//   - opcode_known(): true for every opcode the FSM can sequence
// ----------------------------------------------------------------------------
package control_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_SLTI  = 6'b001010;
  localparam logic [5:0] OP_SLTIU = 6'b001011;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_XORI  = 6'b001110;
  localparam logic [5:0] OP_LUI   = 6'b001111;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  typedef enum logic [3:0] {
    ST_START     = 4'd0,
    ST_FETCH     = 4'd1,
    ST_DECODE    = 4'd2,
    ST_MEM_ADDR  = 4'd3,
    ST_MEM_READ  = 4'd4,
    ST_MEM_WB    = 4'd5,
    ST_MEM_WRITE = 4'd6,
    ST_R_EXEC    = 4'd7,
    ST_R_WB      = 4'd8,
    ST_BRANCH    = 4'd9,
    ST_JUMP      = 4'd10,
    ST_I_EXEC    = 4'd11,
    ST_I_WB      = 4'd12
  } state_e;

  localparam logic [2:0] ULA_OP_ADD   = 3'b000;
  localparam logic [2:0] ULA_OP_SUB   = 3'b001;
  localparam logic [2:0] ULA_OP_RTYPE = 3'b010;
  localparam logic [2:0] ULA_OP_SLT   = 3'b011;
  localparam logic [2:0] ULA_OP_AND   = 3'b100;
  localparam logic [2:0] ULA_OP_OR    = 3'b101;
  localparam logic [2:0] ULA_OP_XOR   = 3'b110;
  localparam logic [2:0] ULA_OP_LUI   = 3'b111;

  localparam logic [1:0] SRCB_B       = 2'b00;
  localparam logic [1:0] SRCB_FOUR    = 2'b01;
  localparam logic [1:0] SRCB_IMM     = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  function automatic logic opcode_known(input logic [5:0] op);
    case (op)
      OP_RTYPE, OP_J, OP_BEQ, OP_BNE, OP_LW, OP_SW,
      OP_ADDI, OP_SLTI, OP_SLTIU, OP_ANDI, OP_ORI, OP_XORI, OP_LUI:
        opcode_known = 1'b1;
      default:
        opcode_known = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/ula_op_encoder.sv
// ----------------------------------------------------------------------------
// ula_op_encoder
// Combinational map from an I-type opcode to the 3-bit ula_operation code
// used during I_EXEC. Non-I-type opcodes map to add.
// Ports:
//   i_opcode         in  6  IR[31:26]
//   o_ula_operation  out 3  ALU operation class for the I-type instruction
// ----------------------------------------------------------------------------
module ula_op_encoder
  import control_pkg::*;
(
  input  logic [5:0] i_opcode,
  output logic [2:0] o_ula_operation
);

  always_comb begin
    o_ula_operation = ULA_OP_ADD;
    case (i_opcode)
      OP_ADDI:            o_ula_operation = ULA_OP_ADD;
      OP_SLTI, OP_SLTIU:  o_ula_operation = ULA_OP_SLT;
      OP_ANDI:            o_ula_operation = ULA_OP_AND;
      OP_ORI:             o_ula_operation = ULA_OP_OR;
      OP_XORI:            o_ula_operation = ULA_OP_XOR;
      OP_LUI:             o_ula_operation = ULA_OP_LUI;
      default:            o_ula_operation = ULA_OP_ADD;
    endcase
  end

endmodule

// File: rtl/multicycle_control.sv
// ----------------------------------------------------------------------------
// multicycle_control
// Moore main-control FSM for the multicycle MIPS datapath. Sequences each
// instruction through fetch / decode / execute / memory / write-back and
// drives datapath enables, mux selects and the 3-bit ula_operation code.
//
// Optional feature macro: MULTICYCLE_MEM_HANDSHAKE_EN
//   defined   : FETCH, MEM_READ and MEM_WRITE hold until mem_ready = 1;
//               ir_write/pc_write in FETCH are gated by mem_ready.
//   undefined : every memory state lasts one cycle; mem_ready is ignored.
//
// Ports:
//   clock, reset (async, active-high)
//   opcode      in  6  IR[31:26]
//   mem_ready   in  1  memory access complete (handshake build only)
//   pc_write, pc_write_cond, branch_ne, i_or_d, mem_read, mem_write,
//   ir_write, reg_dst, reg_write, mem_to_reg, ula_src_a        out 1
//   ula_src_b, pc_source                                       out 2
//   ula_operation                                              out 3
//   illegal_op  out 1  DECODE-cycle pulse on an unknown opcode
// ----------------------------------------------------------------------------
module multicycle_control
  import control_pkg::*;
(
  input  logic       clock,
  input  logic       reset,
  input  logic [5:0] opcode,
  input  logic       mem_ready,
  output logic       pc_write,
  output logic       pc_write_cond,
  output logic       branch_ne,
  output logic       i_or_d,
  output logic       mem_read,
  output logic       mem_write,
  output logic       ir_write,
  output logic       reg_dst,
  output logic       reg_write,
  output logic       mem_to_reg,
  output logic       ula_src_a,
  output logic [1:0] ula_src_b,
  output logic [1:0] pc_source,
  output logic [2:0] ula_operation,
  output logic       illegal_op
);

  state_e     r_state;
  state_e     w_next;
  logic       w_mem_done;
  logic [2:0] w_itype_op;

`ifdef MULTICYCLE_MEM_HANDSHAKE_EN
  assign w_mem_done = mem_ready;
`else
  logic w_unused_mem_ready;
  assign w_unused_mem_ready = mem_ready;
  assign w_mem_done = 1'b1;
`endif

  ula_op_encoder u_ula_op_encoder (
    .i_opcode        (opcode),
    .o_ula_operation (w_itype_op)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) r_state <= ST_START;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_START:     w_next = ST_FETCH;
      ST_FETCH:     w_next = w_mem_done ? ST_DECODE : ST_FETCH;
      ST_DECODE: begin
        case (opcode)
          OP_LW, OP_SW:     w_next = ST_MEM_ADDR;
          OP_RTYPE:         w_next = ST_R_EXEC;
          OP_BEQ, OP_BNE:   w_next = ST_BRANCH;
          OP_J:             w_next = ST_JUMP;
          OP_ADDI, OP_SLTI, OP_SLTIU, OP_ANDI, OP_ORI, OP_XORI, OP_LUI:
                            w_next = ST_I_EXEC;
          default:          w_next = ST_FETCH;  // illegal: drop and refetch
        endcase
      end
      ST_MEM_ADDR:  w_next = (opcode == OP_SW) ? ST_MEM_WRITE : ST_MEM_READ;
      ST_MEM_READ:  w_next = w_mem_done ? ST_MEM_WB : ST_MEM_READ;
      ST_MEM_WB:    w_next = ST_FETCH;
      ST_MEM_WRITE: w_next = w_mem_done ? ST_FETCH : ST_MEM_WRITE;
      ST_R_EXEC:    w_next = ST_R_WB;
      ST_R_WB:      w_next = ST_FETCH;
      ST_BRANCH:    w_next = ST_FETCH;
      ST_JUMP:      w_next = ST_FETCH;
      ST_I_EXEC:    w_next = ST_I_WB;
      ST_I_WB:      w_next = ST_FETCH;
      default:      w_next = ST_START;
    endcase
  end

  always_comb begin
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    branch_ne     = 1'b0;
    i_or_d        = 1'b0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    ir_write      = 1'b0;
    reg_dst       = 1'b0;
    reg_write     = 1'b0;
    mem_to_reg    = 1'b0;
    ula_src_a     = 1'b0;
    ula_src_b     = SRCB_B;
    pc_source     = PCSRC_ALU;
    ula_operation = ULA_OP_ADD;
    case (r_state)
      ST_FETCH: begin
        mem_read  = 1'b1;
        ula_src_b = SRCB_FOUR;
        // Gated so IR load and PC+4 happen once, on the completing cycle.
        ir_write  = w_mem_done;
        pc_write  = w_mem_done;
      end
      ST_DECODE:    ula_src_b = SRCB_IMM_SH2;
      ST_MEM_ADDR: begin
        ula_src_a = 1'b1;
        ula_src_b = SRCB_IMM;
      end
      ST_MEM_READ: begin
        mem_read = 1'b1;
        i_or_d   = 1'b1;
      end
      ST_MEM_WB: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
      end
      ST_MEM_WRITE: begin
        mem_write = 1'b1;
        i_or_d    = 1'b1;
      end
      ST_R_EXEC: begin
        ula_src_a     = 1'b1;
        ula_operation = ULA_OP_RTYPE;
      end
      ST_R_WB: begin
        reg_dst   = 1'b1;
        reg_write = 1'b1;
      end
      ST_BRANCH: begin
        ula_src_a     = 1'b1;
        ula_operation = ULA_OP_SUB;
        pc_write_cond = 1'b1;
        pc_source     = PCSRC_ALUOUT;
        branch_ne     = (opcode == OP_BNE);
      end
      ST_JUMP: begin
        pc_write  = 1'b1;
        pc_source = PCSRC_JUMP;
      end
      ST_I_EXEC: begin
        ula_src_a     = 1'b1;
        ula_src_b     = SRCB_IMM;
        ula_operation = w_itype_op;
      end
      ST_I_WB:      reg_write = 1'b1;
      default: ;
    endcase
  end

  assign illegal_op = (r_state == ST_DECODE) && !opcode_known(opcode);

endmodule

// File: tb/tb_multicycle_control.sv
module tb_multicycle_control;

  logic       clock = 1'b0;
  logic       reset;
  logic [5:0] opcode;
  logic       mem_ready;
  logic       pc_write, pc_write_cond, branch_ne, i_or_d, mem_read, mem_write;
  logic       ir_write, reg_dst, reg_write, mem_to_reg, ula_src_a, illegal_op;
  logic [1:0] ula_src_b, pc_source;
  logic [2:0] ula_operation;

  multicycle_control dut (
    .clock         (clock),
    .reset         (reset),
    .opcode        (opcode),
    .mem_ready     (mem_ready),
    .pc_write      (pc_write),
    .pc_write_cond (pc_write_cond),
    .branch_ne     (branch_ne),
    .i_or_d        (i_or_d),
    .mem_read      (mem_read),
    .mem_write     (mem_write),
    .ir_write      (ir_write),
    .reg_dst       (reg_dst),
    .reg_write     (reg_write),
    .mem_to_reg    (mem_to_reg),
    .ula_src_a     (ula_src_a),
    .ula_src_b     (ula_src_b),
    .pc_source     (pc_source),
    .ula_operation (ula_operation),
    .illegal_op    (illegal_op)
  );

  always #5 clock = ~clock;

  // Order: pcw pcwc bne iord mr mw irw rdst rw m2r sa sb[2] ps[2] op[3] ill
  logic [18:0] w_act;
  assign w_act = {pc_write, pc_write_cond, branch_ne, i_or_d, mem_read, mem_write,
                  ir_write, reg_dst, reg_write, mem_to_reg, ula_src_a, ula_src_b,
                  pc_source, ula_operation, illegal_op};

  typedef enum {S_FETCH, S_FWAIT, S_DECODE, S_ILL, S_MADDR, S_MREAD, S_MWB,
                S_MWR, S_REX, S_RWB, S_BR, S_J, S_IEX, S_IWB} ts_e;
  typedef enum {K_LW, K_SW, K_R, K_I, K_BEQ, K_BNE, K_J, K_ILL} kind_e;
  typedef struct {
    logic [5:0] opc;
    kind_e      kind;
    logic [2:0] iop;
    string      name;
  } vec_t;

  int checks = 0;
  int errors = 0;
  logic [18:0] exp_q[$];
  string       tag_q[$];
  vec_t        vecs[16];

  function automatic logic [18:0] ew(input ts_e s, input logic [2:0] op, input logic bf);
    logic pcw, pcwc, bne, iord, mr, mw, irw, rdst, rw, m2r, sa, ill;
    logic [1:0] sb, ps;
    logic [2:0] uop;
    {pcw, pcwc, bne, iord, mr, mw, irw, rdst, rw, m2r, sa, ill} = '0;
    sb = 2'b00; ps = 2'b00; uop = 3'b000;
    case (s)
      S_FETCH:  begin mr = 1; sb = 2'b01; irw = 1; pcw = 1; end
      S_FWAIT:  begin mr = 1; sb = 2'b01; end
      S_DECODE: sb = 2'b11;
      S_ILL:    begin sb = 2'b11; ill = 1; end
      S_MADDR:  begin sa = 1; sb = 2'b10; end
      S_MREAD:  begin mr = 1; iord = 1; end
      S_MWB:    begin rw = 1; m2r = 1; end
      S_MWR:    begin mw = 1; iord = 1; end
      S_REX:    begin sa = 1; uop = 3'b010; end
      S_RWB:    begin rdst = 1; rw = 1; end
      S_BR:     begin sa = 1; uop = 3'b001; pcwc = 1; ps = 2'b01; bne = bf; end
      S_J:      begin pcw = 1; ps = 2'b10; end
      S_IEX:    begin sa = 1; sb = 2'b10; uop = op; end
      S_IWB:    rw = 1;
      default: ;
    endcase
    return {pcw, pcwc, bne, iord, mr, mw, irw, rdst, rw, m2r, sa, sb, ps, uop, ill};
  endfunction

  task automatic push(input ts_e s, input logic [2:0] op, input logic bf, input string tag);
    exp_q.push_back(ew(s, op, bf));
    tag_q.push_back(tag);
  endtask

  task automatic check_now(input logic [18:0] e, input string tag);
    checks++;
    if (w_act !== e) begin
      errors++;
      $display("FAIL %s actual=%b required=%b", tag, w_act, e);
    end
  endtask

  // One clock: drive mem_ready for the new cycle, then compare the oldest expectation.
  task automatic cycle(input logic mr);
    logic [18:0] e;
    string t;
    @(posedge clock);
    #1 mem_ready = mr;
    #1;
    if (exp_q.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL scoreboard_empty actual=%b required=none", w_act);
    end else begin
      e = exp_q.pop_front();
      t = tag_q.pop_front();
      check_now(e, t);
    end
  endtask

  task automatic run_vec(input vec_t v);
    push(S_FETCH, 3'b000, 1'b0, {v.name, "_fetch"});
    push(v.kind == K_ILL ? S_ILL : S_DECODE, 3'b000, 1'b0, {v.name, "_decode"});
    case (v.kind)
      K_LW: begin
        push(S_MADDR, 3'b000, 1'b0, {v.name, "_maddr"});
        push(S_MREAD, 3'b000, 1'b0, {v.name, "_mread"});
        push(S_MWB,   3'b000, 1'b0, {v.name, "_mwb"});
      end
      K_SW: begin
        push(S_MADDR, 3'b000, 1'b0, {v.name, "_maddr"});
        push(S_MWR,   3'b000, 1'b0, {v.name, "_mwrite"});
      end
      K_R: begin
        push(S_REX, 3'b000, 1'b0, {v.name, "_rexec"});
        push(S_RWB, 3'b000, 1'b0, {v.name, "_rwb"});
      end
      K_I: begin
        push(S_IEX, v.iop, 1'b0, {v.name, "_iexec"});
        push(S_IWB, 3'b000, 1'b0, {v.name, "_iwb"});
      end
      K_BEQ: push(S_BR, 3'b000, 1'b0, {v.name, "_branch"});
      K_BNE: push(S_BR, 3'b000, 1'b1, {v.name, "_branch"});
      K_J:   push(S_J,  3'b000, 1'b0, {v.name, "_jump"});
      default: ;
    endcase
    cycle(1'b1);
    opcode = v.opc;  // changed only once FETCH is reached
    while (exp_q.size() > 0) cycle(1'b1);
  endtask

  initial begin
    vecs[0]  = '{6'b100011, K_LW,  3'b000, "lw"};
    vecs[1]  = '{6'b000000, K_R,   3'b000, "rtype"};
    vecs[2]  = '{6'b001101, K_I,   3'b101, "ori"};
    vecs[3]  = '{6'b101011, K_SW,  3'b000, "sw"};
    vecs[4]  = '{6'b000101, K_BNE, 3'b000, "bne"};
    vecs[5]  = '{6'b000100, K_BEQ, 3'b000, "beq"};
    vecs[6]  = '{6'b000010, K_J,   3'b000, "j"};
    vecs[7]  = '{6'b001000, K_I,   3'b000, "addi"};
    vecs[8]  = '{6'b001010, K_I,   3'b011, "slti"};
    vecs[9]  = '{6'b001011, K_I,   3'b011, "sltiu"};
    vecs[10] = '{6'b001100, K_I,   3'b100, "andi"};
    vecs[11] = '{6'b001110, K_I,   3'b110, "xori"};
    vecs[12] = '{6'b001111, K_I,   3'b111, "lui"};
    vecs[13] = '{6'b111111, K_ILL, 3'b000, "ill_3f"};
    vecs[14] = '{6'b000001, K_ILL, 3'b000, "ill_01"};
    vecs[15] = '{6'b100011, K_LW,  3'b000, "lw_after_ill"};

    mem_ready = 1'b1;
    opcode    = 6'b000000;
    reset     = 1'b1;
    repeat (2) @(posedge clock);
    #2 check_now(19'd0, "reset_hold");
    @(negedge clock) reset = 1'b0;
    #1 check_now(19'd0, "start_after_release");

    foreach (vecs[i]) run_vec(vecs[i]);

`ifdef MULTICYCLE_MEM_HANDSHAKE_EN
    // sw with 3 wait cycles in FETCH and in MEM_WRITE: 10 cycles total.
    for (int k = 0; k < 3; k++) push(S_FWAIT, 3'b000, 1'b0, "hs_fetch_wait");
    push(S_FETCH, 3'b000, 1'b0, "hs_fetch_done");
    push(S_DECODE, 3'b000, 1'b0, "hs_decode");
    push(S_MADDR, 3'b000, 1'b0, "hs_maddr");
    for (int k = 0; k < 4; k++) push(S_MWR, 3'b000, 1'b0, "hs_mwrite");
    cycle(1'b0);
    opcode = 6'b101011;
    cycle(1'b0); cycle(1'b0); cycle(1'b1);
    cycle(1'b1); cycle(1'b1);
    cycle(1'b0); cycle(1'b0); cycle(1'b0); cycle(1'b1);
`else
    // mem_ready held low must not stall anything in the default build.
    push(S_FETCH, 3'b000, 1'b0, "noh_fetch");
    push(S_DECODE, 3'b000, 1'b0, "noh_decode");
    push(S_MADDR, 3'b000, 1'b0, "noh_maddr");
    push(S_MWR, 3'b000, 1'b0, "noh_mwrite");
    cycle(1'b0);
    opcode = 6'b101011;
    while (exp_q.size() > 0) cycle(1'b0);
`endif

    // Reset while in R_EXEC: outputs drop at once, no write-back afterwards.
    push(S_FETCH, 3'b000, 1'b0, "rst_fetch");
    push(S_DECODE, 3'b000, 1'b0, "rst_decode");
    push(S_REX, 3'b000, 1'b0, "rst_rexec");
    cycle(1'b1);
    opcode = 6'b000000;
    cycle(1'b1);
    cycle(1'b1);
    #1 reset = 1'b1;
    #1 check_now(19'd0, "reset_async_mid_rexec");
    for (int k = 0; k < 2; k++) begin
      @(posedge clock);
      #2 check_now(19'd0, "reset_held_mid");
    end
    @(negedge clock) reset = 1'b0;
    #1 check_now(19'd0, "start_after_mid_reset");
    push(S_FETCH, 3'b000, 1'b0, "fetch_after_mid_reset");
    cycle(1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/multicycle_control.md
# multicycle_control

Main control FSM for the multicycle MIPS datapath. It sequences each instruction through fetch, decode, execute, memory and write-back. Per state, it drives the datapath enables and muxes and the 3-bit `ula_operation` code that the ALU control decoder turns into a 4-bit ALU operation. Memory states can optionally wait on a ready handshake.

## Interface
Parameters:
- none

Ports:
- `clock`  in  1  sole clock, rising edge
- `reset`  in  1  asynchronous, active-high
- `opcode`  in  6  IR[31:26]; stable from the cycle after FETCH completes
- `mem_ready`  in  1  memory access done (used only with MEM_HANDSHAKE_EN)
- `pc_write`, `pc_write_cond`, `branch_ne`  out  1 each  PC update controls
- `i_or_d`, `mem_read`, `mem_write`, `ir_write`  out  1 each  memory/IR controls
- `reg_dst`, `reg_write`, `mem_to_reg`, `ula_src_a`  out  1 each  register file/ALU muxes
- `ula_src_b`  out  2  00 = B, 01 = 4, 10 = sign-extended immediate, 11 = immediate<<2
- `pc_source`  out  2  00 = ALU, 01 = ALUOut, 10 = jump target
- `ula_operation`  out  3  000 add, 001 sub, 010 R-type, 011 slti/sltiu, 100 andi, 101 ori, 110 xori, 111 lui
- `illegal_op`  out  1  one-cycle pulse on an unknown opcode

## Operation
- Moore FSM. States: START, FETCH, DECODE, MEM_ADDR, MEM_READ, MEM_WB, MEM_WRITE, R_EXEC, R_WB, BRANCH, JUMP, I_EXEC, I_WB.
- Every output not listed for a state is 0, and `ula_operation` is 000.
- START: all outputs 0 → FETCH.
- FETCH: `mem_read` = 1, `ula_src_b` = 01, `ir_write` = `pc_write` = 1 → DECODE.
- DECODE: `ula_src_b` = 11 (branch target into ALUOut). Next state by `opcode`:
  - 100011 / 101011 → MEM_ADDR
  - 000000 → R_EXEC
  - 000100 / 000101 → BRANCH
  - 000010 → JUMP
  - 001000, 001010, 001011, 001100, 001101, 001110, 001111 → I_EXEC
  - any other opcode → FETCH, with `illegal_op` = 1 during this DECODE cycle
- MEM_ADDR: `ula_src_a` = 1, `ula_src_b` = 10 → MEM_READ (lw) or MEM_WRITE (sw).
- MEM_READ: `mem_read` = `i_or_d` = 1 → MEM_WB.
- MEM_WB: `reg_write` = `mem_to_reg` = 1 → FETCH.
- MEM_WRITE: `mem_write` = `i_or_d` = 1 → FETCH.
- R_EXEC: `ula_src_a` = 1, `ula_operation` = 010 → R_WB.
- R_WB: `reg_dst` = `reg_write` = 1 → FETCH.
- BRANCH: `ula_src_a` = 1, `ula_operation` = 001, `pc_write_cond` = 1, `pc_source` = 01, `branch_ne` = (opcode == 000101) → FETCH.
- JUMP: `pc_write` = 1, `pc_source` = 10 → FETCH.
- I_EXEC: `ula_src_a` = 1, `ula_src_b` = 10, `ula_operation` from opcode:
  - addi → 000
  - slti / sltiu → 011
  - andi → 100, ori → 101, xori → 110, lui → 111
  - → I_WB
- I_WB: `reg_write` = 1, `reg_dst` = 0 → FETCH.

## Timing
- Reset asserted: state goes to START immediately (async) and every output is 0 in that same cycle.
- First FETCH is the cycle after reset deasserts.
- Reset mid-instruction aborts it; no partial write-back is issued afterwards.
- Cycles per instruction without waits: beq/bne 3, j 3, R-type 4, sw 4, I-type 4, lw 5, illegal 2.
- All outputs are combinational from the state register only. `illegal_op` is the exception: it decodes state plus opcode.
- `opcode` is sampled only in DECODE, MEM_ADDR, BRANCH and I_EXEC.

## Configuration
- `MULTICYCLE_MEM_HANDSHAKE_EN` defined:
  - FETCH, MEM_READ and MEM_WRITE hold until `mem_ready` = 1. Memory controls stay asserted while waiting.
  - In FETCH, `ir_write` and `pc_write` are gated by `mem_ready`, so each fires exactly once.
  - `mem_ready` high in the first cycle gives zero added latency.
- Undefined: each memory state lasts exactly 1 cycle and `mem_ready` is ignored.

## Structure
- Package `control_pkg`: opcode constants, state enum, `ula_operation` code constants (shared with the ALU control decoder), `ula_src_b`/`pc_source` select constants.
- Sub-module `ula_op_encoder`: combinational opcode → I-type `ula_operation`.

## Test plan
- Reset mid-R_EXEC → all outputs 0 while reset is high; FETCH one cycle after release; `reg_write` never pulses.
- lw (100011) → FETCH, DECODE, MEM_ADDR, MEM_READ, MEM_WB. `reg_write` = `mem_to_reg` = 1 only in cycle 5; `ula_operation` = 000 throughout.
- R-type then ori (001101) → 010 in R_EXEC, R_WB has `reg_dst` = 1; 101 in I_EXEC, I_WB has `reg_dst` = 0.
- bne (000101) → BRANCH on cycle 3 with `pc_write_cond` = 1, `branch_ne` = 1, `ula_operation` = 001, `pc_source` = 01.
- Opcode 111111 → `illegal_op` pulses one cycle in DECODE, next state FETCH, no writes.
- With the macro, `mem_ready` low for 3 cycles in FETCH and MEM_WRITE → each state lasts 4 cycles; `pc_write` and `ir_write` fire once; sw totals 10 cycles.
